// File: rtl/seg_scan_if.sv
// ============================================================================
// Module      : seg_scan_if
// Description : Digit-pattern load/control and multiplexed display bundle for
//               the 4-digit segment scan controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seg_scan_if;
  logic [6:0] digit0;
  logic [6:0] digit1;
  logic [6:0] digit2;
  logic [6:0] digit3;
  logic       load;
  logic       lz_blank;
  logic       blink_en;
  logic [6:0] seg;
  logic [3:0] an;
  logic       frame_done;

  modport master (
    output digit0, digit1, digit2, digit3, load, lz_blank, blink_en,
    input  seg, an, frame_done
  );

  modport slave (
    input  digit0, digit1, digit2, digit3, load, lz_blank, blink_en,
    output seg, an, frame_done
  );
endinterface

`default_nettype wire

// File: rtl/seg_scan_controller.sv
// ============================================================================
// Module      : seg_scan_controller
// Description : Time-multiplexes four active-low 7-segment patterns onto a
//               common-anode display with dead time, LZ blanking and blink.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seg_scan_controller #(
  parameter int REFRESH_DIV  = 100000,
  parameter int DEAD_CYCLES  = 16,
  parameter int BLINK_FRAMES = 128
) (
  input  wire logic   clk,
  input  wire logic   reset,
  seg_scan_if.slave   bus
);

  localparam int PRESC_W = $clog2(REFRESH_DIV);
  localparam int FC_W    = $clog2(BLINK_FRAMES + 1);

  localparam logic [6:0]         SEG_BLANK  = 7'b1111111;
  localparam logic [6:0]         SEG_ZERO   = 7'b0000001;
  localparam logic [3:0]         AN_OFF     = 4'b1111;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(REFRESH_DIV - 1);
  localparam logic [PRESC_W-1:0] DEAD_END   = PRESC_W'(DEAD_CYCLES);
  localparam logic [FC_W-1:0]    FC_LAST    = FC_W'(BLINK_FRAMES);

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_t;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [1:0]         slot_q, slot_d;
  logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
  phase_t             phase_q, phase_d;
  logic [3:0][6:0]    pending_q, pending_d;
  logic [3:0][6:0]    active_q, active_d;
  logic [6:0]         seg_q, seg_d;
  logic [3:0]         an_q, an_d;
  logic               frame_done_q, frame_done_d;

  logic               wrap;
  logic               boundary;
  logic [3:0]         blank_digit;
  logic               lit;

  always_comb begin
    wrap        = (presc_q == PRESC_LAST);
    boundary    = wrap && (slot_q == 2'd3);
    presc_d     = wrap ? '0 : presc_q + PRESC_W'(1);
    slot_d      = wrap ? slot_q + 2'd1 : slot_q;
    pending_d   = bus.load ? {bus.digit3, bus.digit2, bus.digit1, bus.digit0}
                           : pending_q;
    active_d    = boundary ? pending_q : active_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (boundary) begin
      if (frame_cnt_q + FC_W'(1) == FC_LAST) begin
        frame_cnt_d = '0;
        phase_d     = (phase_q == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        frame_cnt_d = frame_cnt_q + FC_W'(1);
      end
    end
  end

  // Outputs are computed from the post-edge state so they line up with the counters.
  always_comb begin
    blank_digit[3] = bus.lz_blank && (active_d[3] == SEG_ZERO);
    blank_digit[2] = blank_digit[3] && (active_d[2] == SEG_ZERO);
    blank_digit[1] = blank_digit[2] && (active_d[1] == SEG_ZERO);
    blank_digit[0] = 1'b0;

    lit = (presc_d >= DEAD_END) && !blank_digit[slot_d]
          && !(bus.blink_en && (phase_d == PH_OFF));

    an_d         = lit ? ~(4'b0001 << slot_d) : AN_OFF;
    seg_d        = lit ? active_d[slot_d] : SEG_BLANK;
    frame_done_d = boundary;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q      <= '0;
      slot_q       <= 2'd0;
      frame_cnt_q  <= '0;
      phase_q      <= PH_ON;
      pending_q    <= {4{SEG_BLANK}};
      active_q     <= {4{SEG_BLANK}};
      seg_q        <= SEG_BLANK;
      an_q         <= AN_OFF;
      frame_done_q <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      slot_q       <= slot_d;
      frame_cnt_q  <= frame_cnt_d;
      phase_q      <= phase_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      seg_q        <= seg_d;
      an_q         <= an_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign bus.seg        = seg_q;
  assign bus.an         = an_q;
  assign bus.frame_done = frame_done_q;

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_controller.sv
// ============================================================================
// Module      : tb_seg_scan_controller
// Description : Directed self-checking bench for seg_scan_controller
//               (REFRESH_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seg_scan_controller;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;
  int   checks = 0;
  int   errors = 0;

  seg_scan_if bus ();

  seg_scan_controller #(
    .REFRESH_DIV  (8),
    .DEAD_CYCLES  (2),
    .BLINK_FRAMES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cycle index since the last reset edge; cycle 0 is the reset state.
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic goto(input int t);
    int n = 0;
    while (cyc != t && n < 4000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (cyc != t) check("goto_timeout", cyc, t);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] an, input logic [6:0] seg);
    check({tag, "_an"}, bus.an, an);
    check({tag, "_seg"}, bus.seg, seg);
  endtask

  task automatic load_digits(input logic [6:0] d3, input logic [6:0] d2,
                             input logic [6:0] d1, input logic [6:0] d0);
    bus.digit3 = d3;
    bus.digit2 = d2;
    bus.digit1 = d1;
    bus.digit0 = d0;
    bus.load   = 1'b1;
    @(posedge clk);
    #1;
    bus.load   = 1'b0;
  endtask

  initial begin
    bus.digit0   = 7'h7F;
    bus.digit1   = 7'h7F;
    bus.digit2   = 7'h7F;
    bus.digit3   = 7'h7F;
    bus.load     = 1'b0;
    bus.lz_blank = 1'b0;
    bus.blink_en = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_out("rst", 4'b1111, 7'b1111111);
    check("rst_fd", bus.frame_done, 1'b0);
    reset = 1'b0;

    // Idle scan, nothing loaded
    goto(1);  chk_out("dead1", 4'b1111, 7'b1111111);
    goto(2);  chk_out("s0p2", 4'b1110, 7'b1111111);
    goto(7);  chk_out("s0p7", 4'b1110, 7'b1111111);
    goto(8);  chk_out("s1dead", 4'b1111, 7'b1111111);
    goto(10); chk_out("s1p2", 4'b1101, 7'b1111111);
    load_digits(7'b1001100, 7'b0000110, 7'b0010010, 7'b1001111);
    goto(18); chk_out("s2p2_pend", 4'b1011, 7'b1111111);
    goto(26); chk_out("s3p2_pend", 4'b0111, 7'b1111111);
    goto(31); check("fd31", bus.frame_done, 1'b0);
    goto(32); check("fd32", bus.frame_done, 1'b1);
    goto(33); check("fd33", bus.frame_done, 1'b0);
    goto(34); chk_out("f1s0", 4'b1110, 7'b1001111);
    goto(42); chk_out("f1s1", 4'b1101, 7'b0010010);
    goto(58); chk_out("f1s3", 4'b0111, 7'b1001100);
    goto(64); check("fd64", bus.frame_done, 1'b1);

    // Load on the exact boundary edge entering cycle 96
    goto(95);
    bus.lz_blank = 1'b1;
    load_digits(7'b0000001, 7'b0000001, 7'b0100100, 7'b0000001);
    check("fd96", bus.frame_done, 1'b1);
    goto(98);  chk_out("bnd_old", 4'b1110, 7'b1001111);
    goto(122); chk_out("bnd_old3", 4'b0111, 7'b1001100);
    goto(128); check("fd128", bus.frame_done, 1'b1);
    goto(130); chk_out("lz_s0", 4'b1110, 7'b0000001);
    goto(138); chk_out("lz_s1", 4'b1101, 7'b0100100);
    goto(140); load_digits(7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001);
    goto(146); chk_out("lz_s2", 4'b1111, 7'b1111111);
    goto(154); chk_out("lz_s3", 4'b1111, 7'b1111111);
    goto(162); chk_out("lz0_s0", 4'b1110, 7'b0000001);
    goto(170); chk_out("lz0_s1", 4'b1111, 7'b1111111);
    goto(175); bus.lz_blank = 1'b0;
    goto(178); chk_out("nolz_s2", 4'b1011, 7'b0000001);

    // Blink: phase OFF in frames 6-7 and 10-11, ON in 5 and 8-9
    goto(180); bus.blink_en = 1'b1;
    goto(186); chk_out("blk_f5", 4'b0111, 7'b0000001);
    goto(194); chk_out("blk_f6a", 4'b1111, 7'b1111111);
    goto(202); chk_out("blk_f6b", 4'b1111, 7'b1111111);
    goto(250); chk_out("blk_f7", 4'b1111, 7'b1111111);
    goto(258); chk_out("blk_f8", 4'b1110, 7'b0000001);
    goto(290); chk_out("blk_f9", 4'b1110, 7'b0000001);
    goto(322); chk_out("blk_f10", 4'b1111, 7'b1111111);
    bus.blink_en = 1'b0;
    goto(323); chk_out("noblk_f10", 4'b1110, 7'b0000001);

    // Reset in slot 2, prescaler 5
    goto(373); chk_out("pre_rst", 4'b1011, 7'b0000001);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk_out("mid_rst", 4'b1111, 7'b1111111);
    check("mid_rst_fd", bus.frame_done, 1'b0);
    reset = 1'b0;
    goto(2);  chk_out("post_s0", 4'b1110, 7'b1111111);
    goto(10); chk_out("post_s1", 4'b1101, 7'b1111111);
    goto(31); check("post_fd31", bus.frame_done, 1'b0);
    goto(32); check("post_fd32", bus.frame_done, 1'b1);
    goto(34); chk_out("post_f1", 4'b1110, 7'b1111111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_scan_controller.md
Name: seg_scan_controller

Overview:
- Time-multiplexes four 7-segment digit patterns onto one shared segment bus with four active-low anode selects (4-digit common-anode display).
- Sits downstream of the binary-to-7-segment decoder. It captures the decoder's four patterns on a load strobe and commits them only at frame boundaries, so the display never tears.
- Adds anti-ghosting dead time, optional leading-zero blanking and optional blinking.

Parameters:
- REFRESH_DIV, 100000, clock cycles per digit slot (>= 2).
- DEAD_CYCLES, 16, blanked cycles at the start of each slot (0 <= DEAD_CYCLES < REFRESH_DIV).
- BLINK_FRAMES, 128, frames per blink half-period (>= 1).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- digit0  input  7  segment pattern, least significant digit, active-low, bit0 = segment g.
- digit1  input  7  segment pattern, digit 1.
- digit2  input  7  segment pattern, digit 2.
- digit3  input  7  segment pattern, most significant digit.
- load  input  1  capture digit0..3 into pending registers.
- lz_blank  input  1  enable leading-zero blanking.
- blink_en  input  1  enable blinking.
- seg  output  7  shared segment drive, active-low.
- an  output  4  anode selects, active-low; an[i] drives digit i.
- frame_done  output  1  one-cycle pulse at each frame boundary.

Behaviour:
- Clock and reset: one clock domain. Reset is synchronous and active-high.
- Reset values:
  - seg = 7'b1111111, an = 4'b1111, frame_done = 0.
  - Pending and active pattern registers = 7'b1111111 (blank).
  - Slot index = 0, prescaler = 0, frame counter = 0, blink phase = ON.
  - Reset mid-operation discards pending loads and restarts the frame at slot 0, cycle 0.
- Timing:
  - Prescaler counts 0..REFRESH_DIV-1, then wraps.
  - On wrap, the slot index advances 0→1→2→3→0.
  - One frame = 4*REFRESH_DIV cycles.
- Outputs:
  - seg, an and frame_done are registers. They take the value for the new (slot, prescaler) on the same edge the counters advance.
  - Zero combinational paths from inputs to outputs.
- Load:
  - load=1 at an edge copies digit0..3 into the pending registers.
  - Back-to-back loads: the last one wins.
- Commit:
  - On the edge entering slot 0, prescaler 0 (frame boundary, not the first cycle after reset), the active registers take the pre-edge pending contents.
  - frame_done = 1 for exactly that cycle.
  - A load on the boundary edge lands in pending and commits at the next boundary.
- Dead time: while prescaler < DEAD_CYCLES, an = 4'b1111 and seg = 7'b1111111.
- Display:
  - Otherwise an = one-hot-low of the slot index (slot 0 → 4'b1110, slot 3 → 4'b0111).
  - seg = active[slot], unless that digit is blanked.
- Leading-zero blanking (lz_blank=1, evaluated on active registers):
  - digit3 blanks if active3 == 7'b0000001.
  - digit2 blanks if digit3 is blanked and active2 == 7'b0000001.
  - digit1 follows the same rule relative to digit2.
  - digit0 never blanks.
  - A blanked digit gives an = 4'b1111 and seg = 7'b1111111 for the whole slot.
  - lz_blank is sampled each cycle and takes effect on the next output update.
- Blink:
  - The frame counter increments on each frame_done.
  - On reaching BLINK_FRAMES it clears and toggles the blink phase. The phase runs regardless of blink_en.
  - When blink_en=1 and phase=OFF: an = 4'b1111, seg = 7'b1111111.
- Widths:
  - Prescaler = $clog2(REFRESH_DIV) bits.
  - Frame counter = $clog2(BLINK_FRAMES+1) bits.
  - Slot index = 2 bits, wraps naturally.

Test Plan (REFRESH_DIV=8, DEAD_CYCLES=2, BLINK_FRAMES=2; frame = 32 cycles):
- Reset held 3 cycles, then released, no load → seg = 7'b1111111 throughout. an = 4'b1111 in prescaler cycles 0-1, then 4'b1110/1101/1011/0111 in cycles 2-7 of slots 0-3. frame_done pulses at cycles 32, 64, ...
- Load digit0=7'b1001111, digit1=7'b0010010, digit2=7'b0000110, digit3=7'b1001100 at cycle 10 → seg stays blank until frame_done at cycle 32. Then slot 0 cycles 2-7: an=4'b1110, seg=7'b1001111; slot 3: an=4'b0111, seg=7'b1001100.
- lz_blank=1 with digits 3..0 = 0000001, 0000001, 0100100, 0000001 → slots 3 and 2 show an=4'b1111. Slot 1 shows seg=7'b0100100; slot 0 shows seg=7'b0000001. With all four digits 0000001, only slot 0 lights.
- blink_en=1 with a committed pattern → frames 0-1 lit, frames 2-3 an=4'b1111 for all 64 cycles, repeating with a period of 128 cycles. blink_en=0 → always lit.
- Load on the exact boundary edge (cycle 32) → old pattern stays for frame 1. The new pattern appears at cycle 64.
- Reset asserted in slot 2, cycle 5, after a committed load → next cycle an=4'b1111, seg=7'b1111111. After release the counters restart at slot 0, and the display stays blank until a new load commits.
